// File: rtl/tile_loader.sv
// tile_loader: fetches a strided 2-D region byte by byte and emits it
// as fixed-width tiles, one or more per row, zero-padded past row end.
module tile_loader #(
  parameter int TILE_WIDTH = 256,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dram_addr,
  input  logic [11:0]           rows,
  input  logic [19:0]           cols,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic [TILE_WIDTH-1:0] tile_data,
  output logic                  tile_valid,
  input  logic                  tile_ready,
  output logic                  tile_last,
  output logic                  busy,
  output logic                  done
);
  localparam int NB  = TILE_WIDTH / 8;
  localparam int BPE = DATA_WIDTH / 8;
  localparam int JW  = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE, PRIME, READ, OUTPUT, DONE
  } state_t;

  state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_taddr;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [20:0]           r_row_bytes;
  logic [20:0]           r_off;
  logic [11:0]           r_rows_left;
  logic [JW-1:0]         r_j;
  logic [TILE_WIDTH-1:0] r_tile;

  logic [20:0] w_row_bytes;
  logic [21:0] w_pos;
  logic [21:0] w_nxt_pos;
  logic [21:0] w_next_off;
  logic [JW:0] w_jn;
  logic [JW+2:0] w_bit;
  logic w_in_row;
  logic w_last_j;
  logic w_req_nxt;
  logic w_row_more;
  logic w_empty;

  assign w_row_bytes = (BPE == 2) ? {cols, 1'b0}
                                  : {1'b0, cols};
  assign w_pos      = {1'b0, r_off} + 22'(r_j);
  assign w_nxt_pos  = w_pos + 22'd1;
  assign w_next_off = {1'b0, r_off} + 22'(NB);
  assign w_jn       = {1'b0, r_j} + (JW+1)'(1);
  assign w_bit      = {JW'(NB-1) - r_j, 3'b000};
  assign w_in_row   = w_pos < {1'b0, r_row_bytes};
  assign w_last_j   = r_j == JW'(NB-1);
  // byte j+1 is fetched only while it still lies inside the row
  assign w_req_nxt  = !w_last_j &&
                      (w_nxt_pos < {1'b0, r_row_bytes});
  assign w_row_more = w_next_off < {1'b0, r_row_bytes};
  assign w_empty    = (rows == 12'd0) || (cols == 20'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (start) w_next = w_empty ? DONE : PRIME;
      PRIME:
        w_next = READ;
      READ:
        if (w_last_j) w_next = OUTPUT;
      OUTPUT:
        if (tile_ready)
          w_next = (w_row_more || r_rows_left > 12'd1)
                 ? PRIME : DONE;
      DONE:
        w_next = IDLE;
      default:
        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_taddr     <= '0;
      r_stride    <= '0;
      r_row_bytes <= '0;
      r_off       <= '0;
      r_rows_left <= '0;
      r_j         <= '0;
      r_tile      <= '0;
    end else begin
      unique case (r_state)
        IDLE:
          if (start && !w_empty) begin
            r_base      <= dram_addr;
            r_taddr     <= dram_addr;
            r_stride    <= row_stride;
            r_row_bytes <= w_row_bytes;
            r_rows_left <= rows;
            r_off       <= '0;
          end
        PRIME:
          r_j <= '0;
        READ: begin
          r_tile[w_bit +: 8] <= w_in_row ? mem_rdata : 8'h00;
          r_j <= r_j + JW'(1);
        end
        OUTPUT:
          if (tile_ready) begin
            if (w_row_more) begin
              r_off   <= w_next_off[20:0];
              r_taddr <= r_taddr + ADDR_WIDTH'(NB);
            end else begin
              r_off       <= '0;
              r_rows_left <= r_rows_left - 12'd1;
              r_base      <= r_base + r_stride;
              r_taddr     <= r_base + r_stride;
            end
          end
        default: ;
      endcase
    end
  end

  assign mem_re = (r_state == PRIME) ||
                  ((r_state == READ) && w_req_nxt);

  always_comb begin
    mem_addr = '0;
    if (r_state == PRIME)
      mem_addr = r_taddr;
    else if (mem_re)
      mem_addr = r_taddr + ADDR_WIDTH'(w_jn);
  end

  assign tile_data  = r_tile;
  assign tile_valid = r_state == OUTPUT;
  assign tile_last  = tile_valid && !w_row_more &&
                      (r_rows_left == 12'd1);
  assign busy       = r_state != IDLE;
  assign done       = r_state == DONE;

endmodule

// File: tb/tb_tile_loader.sv
// tb_tile_loader: directed and random transfers on 8- and 16-bit element
// instances, checked against a row/tile reference model and a memory model.
module tb_tile_loader;
  localparam int NB = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic ready = 1'b0;
  logic [23:0] dram_addr = '0;
  logic [23:0] row_stride = '0;
  logic [11:0] rows = '0;
  logic [19:0] cols = '0;

  logic re8, re16, valid8, valid16, last8, last16;
  logic busy8, busy16, done8, done16;
  logic [23:0] addr8, addr16;
  logic [255:0] data8, data16;
  logic [7:0] rd8, rd16;

  logic w_re, w_valid, w_last, w_busy, w_done;
  logic [23:0] w_addr;
  logic [255:0] w_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [23:0] got_addr[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tile_loader #(.TILE_WIDTH(256), .DATA_WIDTH(8), .ADDR_WIDTH(24)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel),
    .dram_addr(dram_addr), .rows(rows), .cols(cols),
    .row_stride(row_stride), .mem_re(re8), .mem_addr(addr8),
    .mem_rdata(rd8), .tile_data(data8), .tile_valid(valid8),
    .tile_ready(ready), .tile_last(last8), .busy(busy8), .done(done8)
  );

  tile_loader #(.TILE_WIDTH(256), .DATA_WIDTH(16), .ADDR_WIDTH(24)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start & sel),
    .dram_addr(dram_addr), .rows(rows), .cols(cols),
    .row_stride(row_stride), .mem_re(re16), .mem_addr(addr16),
    .mem_rdata(rd16), .tile_data(data16), .tile_valid(valid16),
    .tile_ready(ready), .tile_last(last16), .busy(busy16), .done(done16)
  );

  assign w_re    = sel ? re16 : re8;
  assign w_addr  = sel ? addr16 : addr8;
  assign w_data  = sel ? data16 : data8;
  assign w_valid = sel ? valid16 : valid8;
  assign w_last  = sel ? last16 : last8;
  assign w_busy  = sel ? busy16 : busy8;
  assign w_done  = sel ? done16 : done8;

  // memory contents: below 0x100 the byte equals its address
  function automatic logic [7:0] f(input logic [23:0] a);
    return a[7:0] ^ (a[15:8] * 8'd13) ^ (a[23:16] * 8'd101);
  endfunction

  always @(posedge clk) begin
    rd8  <= re8 ? f(addr8) : 8'hEE;
    rd16 <= re16 ? f(addr16) : 8'hEE;
  end

  always @(negedge clk) if (w_re) got_addr.push_back(w_addr);

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit s, input logic [23:0] a,
                     input logic [11:0] nr, input logic [19:0] nc,
                     input logic [23:0] st, input int stall);
    logic [255:0] exp_t[$];
    bit exp_l[$];
    logic [23:0] exp_a[$];
    logic [255:0] t, hold;
    logic [23:0] base, ad;
    logic hold_last;
    int rb, nt, nexp, t0, k, waitc, ntiles, hs_cyc, nmis;
    bit seen, fin, first;
    rb = int'(nc) * (s ? 2 : 1);
    nt = (rb + NB - 1) / NB;
    for (int r = 0; r < int'(nr); r++) begin
      base = a + 24'(r) * st;
      for (int ti = 0; ti < nt; ti++) begin
        t = '0;
        for (int j = 0; j < NB; j++) begin
          if (ti * NB + j < rb) begin
            ad = base + 24'(ti * NB + j);
            exp_a.push_back(ad);
            t[(NB-1-j)*8 +: 8] = f(ad);
          end
        end
        exp_t.push_back(t);
        exp_l.push_back(r == int'(nr) - 1 && ti == nt - 1);
      end
    end
    nexp = exp_t.size();
    got_addr.delete();
    @(negedge clk);
    sel = s; dram_addr = a; rows = nr; cols = nc;
    row_stride = st; start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    dram_addr = 24'h5A5A5A; rows = 12'hFFF;
    cols = 20'hFFFFF; row_stride = 24'h123456;
    seen = 0; fin = 0; first = 1; k = 0;
    waitc = 0; ntiles = 0; hs_cyc = -100;
    while (!fin && k < 4000) begin
      if (w_done) begin
        fin = 1;
        start = 1'b0;
        ready = 1'b0;
        if (ntiles == 0) chk("empty_done_lat", cyc - t0, 0);
        else chk("done_lat", cyc - hs_cyc, 1);
      end else begin
        start = ($urandom_range(0, 3) == 0);
        if (w_valid) begin
          if (!seen) begin
            seen = 1; waitc = 0;
            hold = w_data; hold_last = w_last;
            if (first) begin
              first = 0;
              chk("first_valid_lat", cyc - t0, NB + 1);
            end
            ntiles++;
            if (exp_t.size() > 0) begin
              chk("tile_data", w_data, exp_t.pop_front());
              chk("tile_last", w_last, exp_l.pop_front());
            end
          end else begin
            chk("stall_data", w_data, hold);
            chk("stall_last", w_last, hold_last);
            chk("stall_re", w_re, 0);
          end
          if (waitc >= stall) begin
            ready = 1'b1;
            hs_cyc = cyc;
          end else begin
            ready = 1'b0;
          end
          waitc++;
        end else begin
          seen = 0;
          ready = 1'($urandom_range(0, 1));
        end
      end
      if (!fin) begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    chk("finished", fin, 1);
    chk("ntiles", ntiles, nexp);
    chk("re_count", got_addr.size(), exp_a.size());
    nmis = 0;
    for (int i = 0; i < exp_a.size() && i < got_addr.size(); i++)
      if (got_addr[i] !== exp_a[i]) nmis++;
    chk("addr_seq", nmis, 0);
    @(negedge clk);
    chk("done_one_cycle", w_done, 0);
    chk("idle_busy", w_busy, 0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_data", data8, 0);
    chk("rst_valid", valid8, 0);
    chk("rst_last", last8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_re", re8, 0);
    chk("rst_addr", addr8, 0);
    chk("rst16_busy", busy16, 0);
    chk("rst16_re", re16, 0);
    rst_n = 1'b1;

    run(0, 24'h000000, 12'd1, 20'd32, 24'h0, 0);
    run(0, 24'h001234, 12'd1, 20'd40, 24'h0, 2);
    run(1, 24'h004000, 12'd3, 20'd10, 24'd64, 0);
    run(0, 24'h0A0000, 12'd2, 20'd20, 24'h80, 5);
    run(0, 24'h000500, 12'd0, 20'd32, 24'h0, 0);
    run(0, 24'h000500, 12'd3, 20'd0, 24'h0, 0);
    run(0, 24'hFFFFF0, 12'd1, 20'd32, 24'h0, 1);
    run(1, 24'hFFFFE0, 12'd2, 20'd24, 24'h30, 1);

    // abort during the read phase of the second tile
    @(negedge clk);
    sel = 1'b0; dram_addr = 24'h000100; rows = 12'd2;
    cols = 20'd64; row_stride = 24'h100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!valid8 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("abort_first_tile", valid8, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_mid_read_re", re8, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_data", data8, 0);
    chk("abort_valid", valid8, 0);
    chk("abort_last", last8, 0);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_re", re8, 0);
    chk("abort_addr", addr8, 0);
    rst_n = 1'b1;
    run(0, 24'h000200, 12'd1, 20'd40, 24'h0, 0);

    repeat (8) begin
      run(1'($urandom_range(0, 1)), 24'($urandom),
          12'($urandom_range(1, 3)), 20'($urandom_range(1, 50)),
          24'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_loader.md
TILE_LOADER -- requirements
Module: tile_loader

Interface
REQ-001 Parameter TILE_WIDTH, default 256: tile width in bits; SHALL be a multiple of 8 and at least 16; NUM_BYTES = TILE_WIDTH/8.
REQ-002 Parameter DATA_WIDTH, default 8: element width in bits; SHALL be 8 or 16; BPE = DATA_WIDTH/8.
REQ-003 Parameter ADDR_WIDTH, default 24: byte address width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  request pulse; sampled only in IDLE.
REQ-007 dram_addr  in  ADDR_WIDTH  base byte address of row 0.
REQ-008 rows  in  12  number of rows.
REQ-009 cols  in  20  elements per row.
REQ-010 row_stride  in  ADDR_WIDTH  byte pitch between row bases.
REQ-011 mem_re  out  1  byte read request.
REQ-012 mem_addr  out  ADDR_WIDTH  read byte address.
REQ-013 mem_rdata  in  8  read data, valid the cycle after a request.
REQ-014 tile_data  out  TILE_WIDTH  packed tile.
REQ-015 tile_valid  out  1  tile_data valid.
REQ-016 tile_ready  in  1  consumer accepts tile.
REQ-017 tile_last  out  1  qualifies the final tile of the transfer.
REQ-018 busy  out  1  transfer in progress.
REQ-019 done  out  1  one-cycle completion pulse.

Function
REQ-020 States SHALL be IDLE, PRIME, READ, OUTPUT, DONE.
REQ-021 IDLE: start=1 with rows≠0 and cols≠0 -> latch all inputs, row_bytes = cols*BPE (21 bits), go to PRIME; start with rows=0 or cols=0 -> DONE with no reads or tiles.
REQ-022 PRIME: request the first byte of the tile (mem_re=1), go to READ.
REQ-023 READ: capture byte j (j=0..NUM_BYTES-1) into tile_data[(NUM_BYTES-1-j)*8 +: 8], request byte j+1 in the same cycle; after j=NUM_BYTES-1 go to OUTPUT.
REQ-024 Bytes at or beyond row_bytes within the current row SHALL be captured as 0x00 and SHALL NOT be requested (mem_re=0).
REQ-025 OUTPUT: tile_valid=1; tile_data and tile_last held stable until tile_valid&&tile_ready; mem_re=0 throughout.
REQ-026 On handshake: row bytes remain -> PRIME at next sequential address; row exhausted and rows remain -> PRIME at previous row base + row_stride; else -> DONE.
REQ-027 Each row SHALL produce ceil(row_bytes/NUM_BYTES) tiles; tiles never span rows.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE.
REQ-029 busy=1 in PRIME, READ, OUTPUT, DONE; 0 in IDLE.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 Latency: start sampled at cycle T -> PRIME at T+1, first tile_valid at T+2+NUM_BYTES.
REQ-032 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-033 tile_last=1 only while tile_valid=1 on the final tile of the final row.

Reset
REQ-034 rst_n=0 at a clock edge -> IDLE; tile_data=0, tile_valid=0, tile_last=0, busy=0, done=0, mem_re=0, mem_addr=0, all counters 0, from any state including mid-transfer.
REQ-035 After reset release, the first start SHALL be processed normally with no residue of the aborted transfer.

Verification
REQ-036 TILE_WIDTH=256, DATA_WIDTH=8, rows=1, cols=32, mem[A+k]=k -> one tile, byte 0 in [255:248], byte 31 in [7:0], tile_last=1, tile_valid at T+34, done one cycle after handshake.
REQ-037 rows=1, cols=40 -> two tiles; second has bytes 32..39 in [255:192], zeros below; exactly 40 mem_re pulses.
REQ-038 rows=3, cols=10, row_stride=64, DATA_WIDTH=16 -> three tiles from A, A+64, A+128, 20 data bytes each, 12 zero bytes, tile_last only on third.
REQ-039 tile_ready low 5 cycles during OUTPUT -> tile_valid, tile_data, tile_last stable, mem_re=0; transfer resumes after acceptance.
REQ-040 rows=0 -> done at T+1, no tile_valid, no mem_re; dram_addr=0xFFFFF0, cols=32 -> mem_addr wraps to 0x000000 after 0xFFFFFF.
REQ-041 rst_n=0 during READ of tile 2 -> all outputs 0 next cycle; new start yields correct first tile.
